// File: rtl/edge_event_ctrl.sv
// -----------------------------------------------------------------------------
// edge_event_ctrl
//
// Samples an asynchronous serial line, debounces it with a programmable
// prescaler and stability filter, and turns accepted level changes into
// counted events drained through a valid/ready handshake.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cfg_en_i     block enable (synchronizer and handshake run regardless)
//   cfg_div_i    sample period minus one, in clk_i cycles
//   cfg_edge_i   event select: 00 none, 01 rise, 10 fall, 11 both
//   cfg_filt_i   extra consecutive stable samples needed to accept a change
//   clr_i        synchronous clear of pending count and overflow flag
//   serial_i     asynchronous serial input
//   serial_o     filtered level
//   evt_valid_o  at least one event pending
//   evt_ready_i  consumer acknowledge
//   evt_rise_o   type of most recently accepted event (1 rise, 0 fall)
//   evt_cnt_o    number of pending events
//   overflow_o   sticky flag, set when an event is lost
// -----------------------------------------------------------------------------
module edge_event_ctrl #(
    parameter int DivWidth = 16,
    parameter int CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_en_i,
    input  logic [DivWidth-1:0] cfg_div_i,
    input  logic [1:0]          cfg_edge_i,
    input  logic [3:0]          cfg_filt_i,
    input  logic                clr_i,
    input  logic                serial_i,
    output logic                serial_o,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic                evt_rise_o,
    output logic [CntWidth-1:0] evt_cnt_o,
    output logic                overflow_o
);

    localparam logic [DivWidth-1:0] DIV_ONE = {{(DivWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};

    // Two-flop synchronizer; bit 1 is the metastability-safe sample.
    logic [1:0]          sync_reg;

    logic [DivWidth-1:0] div_cnt_reg, div_cnt_next;
    logic [3:0]          stab_reg, stab_next;
    logic                level_reg, level_next;
    logic [CntWidth-1:0] cnt_reg, cnt_next;
    logic                valid_reg, valid_next;
    logic                rise_reg, rise_next;
    logic                ovf_reg, ovf_next;

    logic                sample;
    logic                strobe;
    logic                toggle;
    logic                new_evt;
    logic                handshake;

    assign sample    = sync_reg[1];
    assign strobe    = cfg_en_i && (div_cnt_reg >= cfg_div_i);
    assign handshake = valid_reg && evt_ready_i;

    // Prescaler and stability filter.
    always_comb begin
        div_cnt_next = div_cnt_reg;
        stab_next    = stab_reg;
        level_next   = level_reg;
        toggle       = 1'b0;

        if (!cfg_en_i) begin
            div_cnt_next = '0;
            stab_next    = 4'd0;
        end else begin
            div_cnt_next = strobe ? '0 : div_cnt_reg + DIV_ONE;
            if (strobe) begin
                if (sample != level_reg) begin
                    // A counter left above a lowered threshold falls into
                    // the accept branch on the next differing sample.
                    if (stab_reg < cfg_filt_i) begin
                        stab_next = stab_reg + 4'd1;
                    end else begin
                        toggle     = 1'b1;
                        level_next = ~level_reg;
                        stab_next  = 4'd0;
                    end
                end else begin
                    stab_next = 4'd0;
                end
            end
        end
    end

    // A toggle to 1 is a rise (cfg_edge_i[0]), to 0 a fall (cfg_edge_i[1]).
    assign new_evt = toggle && (level_next ? cfg_edge_i[0] : cfg_edge_i[1]);

    // Pending-event counter, event type and overflow.
    always_comb begin
        cnt_next  = cnt_reg;
        rise_next = rise_reg;
        ovf_next  = ovf_reg;

        if (clr_i) begin
            // A same-cycle event is dropped without touching any state.
            cnt_next = '0;
            ovf_next = 1'b0;
        end else begin
            if (new_evt) begin
                rise_next = level_next;
            end
            unique case ({new_evt, handshake})
                2'b10: begin
                    if (cnt_reg == CNT_MAX) begin
                        ovf_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                2'b01:   cnt_next = cnt_reg - CNT_ONE;
                default: cnt_next = cnt_reg;
            endcase
        end

        valid_next = (cnt_next != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_reg    <= 2'b00;
            div_cnt_reg <= '0;
            stab_reg    <= 4'd0;
            level_reg   <= 1'b0;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            rise_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], serial_i};
            div_cnt_reg <= div_cnt_next;
            stab_reg    <= stab_next;
            level_reg   <= level_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
            rise_reg    <= rise_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign serial_o    = level_reg;
    assign evt_valid_o = valid_reg;
    assign evt_rise_o  = rise_reg;
    assign evt_cnt_o   = cnt_reg;
    assign overflow_o  = ovf_reg;

endmodule

// File: doc/edge_event_ctrl.md
EDGE_EVENT_CTRL -- requirements
Module: edge_event_ctrl

Interface
REQ-001 SHALL have parameter DivWidth, default 16, the width of the sample prescaler.
REQ-002 SHALL have parameter CntWidth, default 8, the width of the pending-event counter.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port cfg_en_i, input, 1, block enable.
REQ-006 SHALL have port cfg_div_i, input, DivWidth, the sample period minus 1, in clk_i cycles.
REQ-007 SHALL have port cfg_edge_i, input, 2, the event select: 00 none, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port cfg_filt_i, input, 4, the number of extra consecutive stable samples required before a level change is accepted.
REQ-009 SHALL have port clr_i, input, 1, a synchronous clear of the pending count and the overflow flag.
REQ-010 SHALL have port serial_i, input, 1, an asynchronous serial line.
REQ-011 SHALL have port serial_o, output, 1, the filtered level.
REQ-012 SHALL have port evt_valid_o, output, 1, asserted when at least one event is pending.
REQ-013 SHALL have port evt_ready_i, input, 1, the consumer acknowledge.
REQ-014 SHALL have port evt_rise_o, output, 1, the type of the most recently accepted event: 1 rise, 0 fall.
REQ-015 SHALL have port evt_cnt_o, output, CntWidth, the number of pending events.
REQ-016 SHALL have port overflow_o, output, 1, a sticky flag set when an event is lost.

Function
REQ-017 SHALL pass serial_i through a two-flop synchronizer that is clocked every cycle regardless of cfg_en_i.
REQ-018 SHALL run a prescaler while cfg_en_i=1, counting 0 upward and issuing a one-cycle sample strobe when count >= cfg_div_i, then reloading 0; cfg_div_i=0 strobes every cycle.
REQ-019 SHALL, while cfg_en_i=0, hold the prescaler at 0, clear the stability counter, hold serial_o, issue no strobes and keep the handshake and pending count operating.
REQ-020 SHALL, on a strobe where the synchronized sample differs from serial_o, increment the stability counter when it is below cfg_filt_i; otherwise it SHALL toggle serial_o and clear the stability counter.
REQ-021 SHALL clear the stability counter on a strobe where the sample equals serial_o, so glitches shorter than cfg_filt_i+1 samples are rejected.
REQ-022 SHALL classify a toggle of serial_o to 1 as a rise and a toggle to 0 as a fall, and SHALL generate an event when the type matches cfg_edge_i.
REQ-023 SHALL assert evt_valid_o = (evt_cnt_o != 0); a handshake is the cycle in which evt_valid_o and evt_ready_i are both 1, and it decrements the count.
REQ-024 SHALL, for a new event and a handshake in the same cycle, leave the count unchanged and update evt_rise_o.
REQ-025 SHALL, for a new event when the count is 2^CntWidth-1 and no handshake occurs, hold the count, set overflow_o and still update evt_rise_o.
REQ-026 SHALL keep overflow_o set until clr_i or reset.
REQ-027 SHALL, on clr_i=1, zero evt_cnt_o and overflow_o; a same-cycle event is discarded and does not set overflow_o.
REQ-028 SHALL, when the stability counter exceeds a lowered cfg_filt_i, accept the change on the next differing strobe.
REQ-029 SHALL, with cfg_div_i=0 and cfg_filt_i=0, change serial_o and raise evt_valid_o exactly 3 clk_i edges after serial_i changes (setup met).
REQ-030 SHALL drive evt_valid_o, evt_rise_o, evt_cnt_o, overflow_o and serial_o directly from registers.

Reset
REQ-031 SHALL, while rst_ni=0, zero all state: synchronizer, prescaler, stability counter, serial_o, evt_cnt_o, evt_rise_o and overflow_o; evt_valid_o is therefore 0.
REQ-032 SHALL, on reset mid-operation, discard pending events, and SHALL report no event on the first sample after reset when serial_i=0.

Verification
REQ-033 SHALL cover: div=0, filt=0, edge=11, serial_i 0->1 with ready=0 -> serial_o=1, cnt=1, rise=1 three edges later.
REQ-034 SHALL cover: div=3, filt=2, serial_i high pulse of 8 cycles (2 samples) -> no event; high for 12 cycles -> one rise event, cnt=1.
REQ-035 SHALL cover: edge=01, 4 full pulses with ready=0 -> cnt=4; then ready=1 for 4 cycles -> cnt=0, valid=0.
REQ-036 SHALL cover: CntWidth=2, 4 rise events with ready=0 -> cnt=3, overflow=1; then clr_i pulse -> cnt=0, overflow=0.
REQ-037 SHALL cover: cnt=1, ready=1 held while a new event arrives -> cnt stays 1, valid stays 1.
REQ-038 SHALL cover: cfg_en_i dropped mid-filter, then serial_i toggled, then enable restored -> no event while disabled; filter restarts from 0.
